timer_apb_ctrl: RTL and testbench
=================================

TIMER_APB_CTRL -- requirements
Module: timer_apb_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 2, number of configuration requesters (1..8).
REQ-002 Parameter NUM_TIMER, default 2, number of timers on the APB slave (1..16).
REQ-003 Parameter PEND_BIT, default 2, bit position of the interrupt-pending flag in a timer CONTROL word.
REQ-004 Clocking SHALL be one clock with an asynchronous, active-low reset, exactly as decided.
REQ-005 PCLK  input  1  the single clock; all state updates on its rising edge.
REQ-006 PRESETn  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  NUM_REQ  per-requester configuration request.
REQ-008 req_ready  output  NUM_REQ  one-cycle grant/accept pulse per requester.
REQ-009 req_timer  input  4*NUM_REQ  target timer index, slice i for requester i.
REQ-010 req_period  input  32*NUM_REQ  PERIOD value, slice i.
REQ-011 req_control  input  32*NUM_REQ  CONTROL value, slice i.
REQ-012 intr_i  input  NUM_TIMER  active-high timer interrupts.
REQ-013 PSEL, PENABLE, PWRITE  output  1 each  APB master controls.
REQ-014 PADDR  output  32  {24'h0, timer[3:0], offset[3:0]}; CONTROL offset 4'h0, PERIOD offset 4'h4.
REQ-015 PWDATA  output  32  write data.  PRDATA  input  32  read data.
REQ-016 intr_count  output  8*NUM_TIMER  per-timer serviced-interrupt counter.
REQ-017 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 APB transfers SHALL be two cycles, SETUP (PSEL=1, PENABLE=0) then ACCESS (PSEL=1, PENABLE=1), with no wait states; PADDR/PWRITE/PWDATA are held stable across both cycles.
REQ-019 FSM states: IDLE, CFG_PER_S, CFG_PER_A, CFG_CTL_S, CFG_CTL_A, ISR_RD_S, ISR_RD_A, ISR_WR_S, ISR_WR_A.
REQ-020 In IDLE, any intr_i bit high SHALL take priority over every request; the lowest-index asserted timer is selected and the FSM goes to ISR_RD_S.
REQ-021 In IDLE, with no interrupt and any req_valid high, a round-robin arbiter SHALL select a requester, starting the search at last-granted+1 (requester 0 after reset).
REQ-022 On a configuration grant, req_ready[i] SHALL pulse for exactly one cycle (the IDLE->CFG_PER_S edge), and timer, period, and control are latched at that edge.
REQ-023 Configuration sequence: write PERIOD (CFG_PER_S/A), then write CONTROL (CFG_CTL_S/A), then return to IDLE; 4 cycles of APB activity.
REQ-024 Interrupt service: read CONTROL (ISR_RD_S/A), capture PRDATA at ISR_RD_A, write back the captured value with bit PEND_BIT cleared (ISR_WR_S/A), increment intr_count[t], then return to IDLE.
REQ-025 intr_count SHALL saturate at 8'hFF and never wrap.
REQ-026 A request whose req_timer is >= NUM_TIMER SHALL be granted (req_ready pulses) but SHALL issue no APB transfer; the FSM returns to IDLE the next cycle.
REQ-027 req_valid deasserting while not granted SHALL be ignored; a sequence, once started, SHALL complete regardless of input changes.
REQ-028 Every IDLE cycle SHALL re-arbitrate, with no bubble beyond the IDLE cycle between back-to-back sequences.
REQ-029 Outside SETUP/ACCESS states, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.

Reset
REQ-030 On PRESETn low, asynchronously: FSM=IDLE, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, req_ready=0, busy=0, intr_count=0, round-robin pointer=requester 0.
REQ-031 Reset mid-sequence SHALL abort it immediately, and no partial transfer SHALL continue after release.

Verification
REQ-032 Req0 with timer=1, period=32'd1000, control=32'h3 -> PADDR 0x14 write 1000, then 0x10 write 3; req_ready[0] is a single pulse; busy for 4 cycles.
REQ-033 req_valid=2'b11 held for 3 sequences -> grant order 0,1,0.
REQ-034 intr_i[1]=1 together with req_valid[0] -> ISR runs first: read 0x10 with PRDATA=32'h7, then write 0x10 with 32'h3; intr_count[1]=1.
REQ-035 256 services on timer 0 -> intr_count[0] stays 8'hFF.
REQ-036 req_timer=4'hF with NUM_TIMER=2 -> req_ready pulses, PSEL stays 0.
REQ-037 PRESETn asserted during CFG_CTL_S -> all outputs at reset values in the same cycle, and no CONTROL write after release.

Source files
------------

// File: rtl/timer_apb_ctrl_if.sv
// APB bus bundle between timer_apb_ctrl (master) and the timer block (slave).
// The spec's upper-case APB signal names are kept as-is.
interface timer_apb_ctrl_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA);
endinterface

// File: rtl/timer_apb_ctrl.sv
// APB master that services timer interrupts (read CONTROL, clear pending, write back)
// and arbitrates round-robin between requesters that program timer PERIOD/CONTROL.
module timer_apb_ctrl #(
  parameter int NUM_REQ   = 2,
  parameter int NUM_TIMER = 2,
  parameter int PEND_BIT  = 2
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [4*NUM_REQ-1:0]   req_timer,
  input  logic [32*NUM_REQ-1:0]  req_period,
  input  logic [32*NUM_REQ-1:0]  req_control,
  input  logic [NUM_TIMER-1:0]   intr_i,
  timer_apb_ctrl_if.master       apb,
  output logic [8*NUM_TIMER-1:0] intr_count,
  output logic                   busy
);

  localparam int          RW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] PEND_MASK = 32'd1 << PEND_BIT;

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] CFG_PER_S = 4'd1;
  localparam logic [3:0] CFG_PER_A = 4'd2;
  localparam logic [3:0] CFG_CTL_S = 4'd3;
  localparam logic [3:0] CFG_CTL_A = 4'd4;
  localparam logic [3:0] ISR_RD_S  = 4'd5;
  localparam logic [3:0] ISR_RD_A  = 4'd6;
  localparam logic [3:0] ISR_WR_S  = 4'd7;
  localparam logic [3:0] ISR_WR_A  = 4'd8;

  logic [3:0]    state;
  logic [3:0]    cur_timer;
  logic [31:0]   cur_period;
  logic [31:0]   cur_control;
  logic [31:0]   rd_data;
  logic          cfg_skip;
  logic [RW-1:0] rr_next;
  logic [7:0]    cnt [NUM_TIMER];

  // Interrupt selection: lowest-index asserted line wins.
  logic       any_intr;
  logic [3:0] intr_sel;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    any_intr = 1'b0;
    intr_sel = '0;
    for (int t = NUM_TIMER - 1; t >= 0; t--) begin
      if (intr_i[t]) begin
        any_intr = 1'b1;
        intr_sel = 4'(t);
      end
    end
  end

  // Round-robin: rotate the request vector so the search starts at rr_next.
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 gnt_found;
  logic [RW-1:0]        gnt_ofs;
  logic [RW:0]          gnt_sum;
  logic [RW-1:0]        gnt_idx;
  logic [RW-1:0]        gnt_after;
  logic [NUM_REQ-1:0]   gnt_onehot;
  logic [3:0]           sel_timer;
  logic [31:0]          sel_period;
  logic [31:0]          sel_control;
  logic                 sel_bad_timer;

  assign req_dbl = {req_valid, req_valid} >> rr_next;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    gnt_found = 1'b0;
    gnt_ofs   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        gnt_found = 1'b1;
        gnt_ofs   = RW'(k);
      end
    end
    gnt_sum = {1'b0, rr_next} + {1'b0, gnt_ofs};
    if (gnt_sum >= (RW+1)'(NUM_REQ)) gnt_idx = RW'(gnt_sum - (RW+1)'(NUM_REQ));
    else                             gnt_idx = gnt_sum[RW-1:0];
    gnt_after = (gnt_idx == RW'(NUM_REQ - 1)) ? '0 : gnt_idx + RW'(1);
  end

  always_comb begin
    gnt_onehot  = '0;
    sel_timer   = '0;
    sel_period  = '0;
    sel_control = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == RW'(i)) begin
        gnt_onehot[i] = gnt_found;
        sel_timer     = req_timer[4*i +: 4];
        sel_period    = req_period[32*i +: 32];
        sel_control   = req_control[32*i +: 32];
      end
    end
    sel_bad_timer = ({1'b0, sel_timer} >= 5'(NUM_TIMER));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      cur_timer   <= '0;
      cur_period  <= '0;
      cur_control <= '0;
      rd_data     <= '0;
      cfg_skip    <= 1'b0;
      rr_next     <= '0;
      req_ready   <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (any_intr) begin
            state     <= ISR_RD_S;
            cur_timer <= intr_sel;
            cfg_skip  <= 1'b0;
          end else if (gnt_found) begin
            // Out-of-range timer: still accepted, but CFG_PER_S becomes a silent one-cycle pass.
            state       <= CFG_PER_S;
            cur_timer   <= sel_timer;
            cur_period  <= sel_period;
            cur_control <= sel_control;
            cfg_skip    <= sel_bad_timer;
            req_ready   <= gnt_onehot;
            rr_next     <= gnt_after;
          end
        end
        CFG_PER_S: state <= cfg_skip ? IDLE : CFG_PER_A;
        CFG_PER_A: state <= CFG_CTL_S;
        CFG_CTL_S: state <= CFG_CTL_A;
        CFG_CTL_A: state <= IDLE;
        ISR_RD_S:  state <= ISR_RD_A;
        ISR_RD_A: begin
          rd_data <= apb.PRDATA;
          state   <= ISR_WR_S;
        end
        ISR_WR_S:  state <= ISR_WR_A;
        ISR_WR_A:  state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // NOTE: the counter array is small register state, so it is reset explicitly like any other flop.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int t = 0; t < NUM_TIMER; t++) cnt[t] <= '0;
    end else if (state == ISR_WR_A) begin
      for (int t = 0; t < NUM_TIMER; t++) begin
        if (cur_timer == 4'(t) && cnt[t] != 8'hFF) cnt[t] <= cnt[t] + 8'd1;
      end
    end
  end

  for (genvar t = 0; t < NUM_TIMER; t++) begin : g_cnt
    assign intr_count[8*t +: 8] = cnt[t];
  end

  assign busy = (state != IDLE);

  // APB outputs decode straight from state, so reset forces them idle in the same cycle.
  always_comb begin
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
    case (state)
      CFG_PER_S, CFG_PER_A: begin
        if (!cfg_skip) begin
          apb.PSEL    = 1'b1;
          apb.PENABLE = (state == CFG_PER_A);
          apb.PWRITE  = 1'b1;
          apb.PADDR   = {24'h0, cur_timer, 4'h4};
          apb.PWDATA  = cur_period;
        end
      end
      CFG_CTL_S, CFG_CTL_A: begin
        apb.PSEL    = 1'b1;
        apb.PENABLE = (state == CFG_CTL_A);
        apb.PWRITE  = 1'b1;
        apb.PADDR   = {24'h0, cur_timer, 4'h0};
        apb.PWDATA  = cur_control;
      end
      ISR_RD_S, ISR_RD_A: begin
        apb.PSEL    = 1'b1;
        apb.PENABLE = (state == ISR_RD_A);
        apb.PADDR   = {24'h0, cur_timer, 4'h0};
      end
      ISR_WR_S, ISR_WR_A: begin
        apb.PSEL    = 1'b1;
        apb.PENABLE = (state == ISR_WR_A);
        apb.PWRITE  = 1'b1;
        apb.PADDR   = {24'h0, cur_timer, 4'h0};
        apb.PWDATA  = rd_data & ~PEND_MASK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// Randomized self-checking bench for timer_apb_ctrl: a transaction-level model predicts
// which sequence each IDLE decision starts and the exact APB cycles it must produce.
module tb_timer_apb_ctrl;
  localparam int          NUM_REQ   = 2;
  localparam int          NUM_TIMER = 2;
  localparam int          PEND_BIT  = 2;
  localparam logic [31:0] PEND_MASK = 32'd1 << PEND_BIT;

  logic                   PCLK = 1'b0;
  logic                   PRESETn;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [4*NUM_REQ-1:0]   req_timer;
  logic [32*NUM_REQ-1:0]  req_period;
  logic [32*NUM_REQ-1:0]  req_control;
  logic [NUM_TIMER-1:0]   intr_i;
  logic [8*NUM_TIMER-1:0] intr_count;
  logic                   busy;

  timer_apb_ctrl_if apb ();

  timer_apb_ctrl #(.NUM_REQ(NUM_REQ), .NUM_TIMER(NUM_TIMER), .PEND_BIT(PEND_BIT)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_timer   (req_timer),
    .req_period  (req_period),
    .req_control (req_control),
    .intr_i      (intr_i),
    .apb         (apb),
    .intr_count  (intr_count),
    .busy        (busy)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Requester-side view and model state.
  bit          v_m   [NUM_REQ];
  logic [3:0]  tmr_m [NUM_REQ];
  logic [31:0] per_m [NUM_REQ];
  logic [31:0] ctl_m [NUM_REQ];
  int          rr_start;
  int          cnt_m [NUM_TIMER];
  int          last_grant;
  bit          rd_force_en;
  logic [31:0] rd_force_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]            = v_m[i];
      req_timer[4*i +: 4]     = tmr_m[i];
      req_period[32*i +: 32]  = per_m[i];
      req_control[32*i +: 32] = ctl_m[i];
    end
  endtask

  task automatic new_fields(input int i);
    if ($urandom_range(0, 7) == 0) tmr_m[i] = 4'($urandom_range(NUM_TIMER, 15));
    else                           tmr_m[i] = 4'($urandom_range(0, NUM_TIMER - 1));
    per_m[i] = $urandom();
    ctl_m[i] = $urandom();
  endtask

  task automatic model_reset();
    rr_start = 0;
    for (int t = 0; t < NUM_TIMER; t++) cnt_m[t] = 0;
    for (int i = 0; i < NUM_REQ; i++) v_m[i] = 1'b0;
    intr_i = '0;
    drive_reqs();
  endtask

  task automatic randomize_stim();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!v_m[i] && $urandom_range(0, 2) == 0) begin
        v_m[i] = 1'b1;
        new_fields(i);
      end
    end
    for (int t = 0; t < NUM_TIMER; t++) if ($urandom_range(0, 5) == 0) intr_i[t] = 1'b1;
    drive_reqs();
  endtask

  // Called at a negedge inside an IDLE cycle with the inputs for the next decision in place;
  // returns at the negedge of the following IDLE cycle.
  task automatic run_episode(input bit keep_intr, input bit keep_req);
    int                 kind;  // 0 idle, 1 isr, 2 config, 3 config to bad timer
    int                 t, g, len;
    logic [31:0]        per, ctl, rd, addr, wdata;
    bit                 wr;
    logic [NUM_REQ-1:0] rdy;
    for (int k = 0; k < NUM_TIMER; k++)
      check($sformatf("intr_count[%0d]", k), 32'(intr_count[8*k +: 8]), 32'(cnt_m[k]));
    check("idle busy", 32'(busy), 32'd0);
    check("idle PSEL", 32'(apb.PSEL), 32'd0);
    check("idle req_ready", 32'(req_ready), 32'd0);
    kind = 0; t = 0; g = 0; per = '0; ctl = '0;
    for (int i = NUM_TIMER - 1; i >= 0; i--) if (intr_i[i]) begin kind = 1; t = i; end
    if (kind == 0) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (v_m[(rr_start + k) % NUM_REQ]) begin
          kind = 2;
          g    = (rr_start + k) % NUM_REQ;
        end
      end
    end
    if (kind == 0) begin
      @(negedge PCLK);
      return;
    end
    if (kind == 2) begin
      t          = int'(tmr_m[g]);
      per        = per_m[g];
      ctl        = ctl_m[g];
      rr_start   = (g + 1) % NUM_REQ;
      last_grant = g;
      if (t >= NUM_TIMER) kind = 3;
    end
    rd          = rd_force_en ? rd_force_val : ($urandom() | PEND_MASK);
    rd_force_en = 1'b0;
    len         = (kind == 3) ? 1 : 4;
    for (int c = 0; c < len; c++) begin
      @(negedge PCLK);
      apb.PRDATA = (kind == 1 && c == 1) ? rd : $urandom();
      rdy = '0;
      if (kind != 1 && c == 0) rdy[g] = 1'b1;
      check($sformatf("req_ready c%0d", c), 32'(req_ready), 32'(rdy));
      check($sformatf("busy c%0d", c), 32'(busy), 32'd1);
      if (kind == 3) begin
        check("bad-timer PSEL", 32'(apb.PSEL), 32'd0);
        check("bad-timer PENABLE", 32'(apb.PENABLE), 32'd0);
        check("bad-timer PADDR", apb.PADDR, 32'd0);
      end else begin
        addr  = {24'h0, 4'(t), (kind == 2 && c < 2) ? 4'h4 : 4'h0};
        wr    = !(kind == 1 && c < 2);
        wdata = (kind == 1) ? (rd & ~PEND_MASK) : ((c < 2) ? per : ctl);
        check($sformatf("PSEL c%0d", c), 32'(apb.PSEL), 32'd1);
        check($sformatf("PENABLE c%0d", c), 32'(apb.PENABLE), 32'(c % 2));
        check($sformatf("PWRITE c%0d", c), 32'(apb.PWRITE), 32'(wr));
        check($sformatf("PADDR c%0d", c), apb.PADDR, addr);
        if (wr) check($sformatf("PWDATA c%0d", c), apb.PWDATA, wdata);
      end
      if (c == 0 && kind != 1) begin
        if (!keep_req) v_m[g] = 1'b0;
        new_fields(g);
        drive_reqs();
      end
    end
    if (kind == 1) begin
      if (cnt_m[t] < 255) cnt_m[t]++;
      if (!keep_intr) intr_i[t] = 1'b0;
    end
    @(negedge PCLK);
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    model_reset();
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp [3] = '{0, 1, 0};
    PRESETn     = 1'b0;
    apb.PRDATA  = '0;
    rd_force_en = 1'b0;
    rd_force_val = '0;
    last_grant  = -1;
    for (int i = 0; i < NUM_REQ; i++) begin v_m[i] = 1'b1; new_fields(i); end
    intr_i = '1;
    drive_reqs();

    // Reset values while inputs are active.
    repeat (2) @(negedge PCLK);
    check("reset busy", 32'(busy), 32'd0);
    check("reset PSEL", 32'(apb.PSEL), 32'd0);
    check("reset PENABLE", 32'(apb.PENABLE), 32'd0);
    check("reset PWRITE", 32'(apb.PWRITE), 32'd0);
    check("reset PADDR", apb.PADDR, 32'd0);
    check("reset PWDATA", apb.PWDATA, 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset intr_count", 32'(intr_count), 32'd0);
    model_reset();
    PRESETn = 1'b1;

    // Both requesters held valid: grants alternate starting at requester 0.
    for (int i = 0; i < NUM_REQ; i++) begin v_m[i] = 1'b1; new_fields(i); end
    drive_reqs();
    for (int n = 0; n < 3; n++) begin
      run_episode(1'b0, 1'b1);
      check($sformatf("rr order #%0d", n), 32'(last_grant), 32'(rr_exp[n]));
    end
    for (int i = 0; i < NUM_REQ; i++) v_m[i] = 1'b0;
    drive_reqs();
    run_episode(1'b0, 1'b0);

    // Single configuration: timer 1, period 1000, control 3.
    v_m[0] = 1'b1; tmr_m[0] = 4'd1; per_m[0] = 32'd1000; ctl_m[0] = 32'h3;
    drive_reqs();
    run_episode(1'b0, 1'b0);
    check("cfg grant", 32'(last_grant), 32'd0);

    // Interrupt beats a simultaneous request; PRDATA 7 is written back as 3.
    v_m[0] = 1'b1; tmr_m[0] = 4'd0; per_m[0] = 32'h1234; ctl_m[0] = 32'h5;
    intr_i = 2'b10;
    drive_reqs();
    rd_force_en = 1'b1; rd_force_val = 32'h7;
    run_episode(1'b0, 1'b0);
    run_episode(1'b0, 1'b0);
    check("isr count timer1", 32'(intr_count[15:8]), 32'd1);

    // Out-of-range timer index: accepted, no APB transfer.
    v_m[0] = 1'b1; tmr_m[0] = 4'hF; per_m[0] = 32'hDEAD; ctl_m[0] = 32'hBEEF;
    drive_reqs();
    run_episode(1'b0, 1'b0);
    run_episode(1'b0, 1'b0);

    // Random mix of requests and interrupts.
    for (int ep = 0; ep < 300; ep++) begin
      randomize_stim();
      run_episode(1'b0, 1'b0);
    end

    // Reset in CFG_CTL_S: outputs clear at once and the CONTROL write never happens.
    for (int i = 0; i < NUM_REQ; i++) v_m[i] = 1'b0;
    intr_i = '0;
    v_m[0] = 1'b1; tmr_m[0] = 4'd1; per_m[0] = 32'hA5A5_0001; ctl_m[0] = 32'hF1;
    drive_reqs();
    @(posedge PCLK);
    #1;
    v_m[0] = 1'b0;
    drive_reqs();
    @(posedge PCLK);
    @(posedge PCLK);
    #2;
    check("pre-reset PSEL", 32'(apb.PSEL), 32'd1);
    check("pre-reset PADDR", apb.PADDR, 32'h10);
    PRESETn = 1'b0;
    #1;
    check("async PSEL", 32'(apb.PSEL), 32'd0);
    check("async PENABLE", 32'(apb.PENABLE), 32'd0);
    check("async PWRITE", 32'(apb.PWRITE), 32'd0);
    check("async PADDR", apb.PADDR, 32'd0);
    check("async PWDATA", apb.PWDATA, 32'd0);
    check("async busy", 32'(busy), 32'd0);
    check("async req_ready", 32'(req_ready), 32'd0);
    check("async intr_count", 32'(intr_count), 32'd0);
    model_reset();
    @(negedge PCLK);
    do_reset();
    for (int n = 0; n < 8; n++) begin
      @(negedge PCLK);
      check($sformatf("post-reset PSEL %0d", n), 32'(apb.PSEL), 32'd0);
      check($sformatf("post-reset busy %0d", n), 32'(busy), 32'd0);
    end

    // Interrupt held on timer 0 for 260 services: the counter must stick at 0xFF.
    intr_i = 2'b01;
    for (int n = 0; n < 260; n++) run_episode(1'b1, 1'b0);
    check("saturated count", 32'(intr_count[7:0]), 32'hFF);
    intr_i = '0;
    run_episode(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
